// File: rtl/banked_field_mem.sv
// Banked line memory with per-row dirty tracking and a single-entry line buffer.
// Field-granular reads and writes; every write goes through to the bank RAM.
module banked_field_mem #(
    parameter int NUM_BANKS   = 4,
    parameter int BANK_DEPTH  = 16,
    parameter int LINE_WIDTH  = 64,
    parameter int FIELD_WIDTH = 16,
    localparam int FIELDS = LINE_WIDTH / FIELD_WIDTH,
    localparam int BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int RW     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
    localparam int CW     = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic                   clear,
    input  logic [BW-1:0]          bank_in,
    input  logic [RW-1:0]          row_addr_in,
    input  logic [CW-1:0]          col_addr_in,
    input  logic [FIELD_WIDTH-1:0] partial_vec_in,
    output logic [FIELD_WIDTH-1:0] partial_vec_out,
    output logic                   ack,
    output logic                   busy,
    output logic                   err
);

    // state | meaning
    // IDLE  | waiting for a request
    // FETCH | bank RAM read in flight
    // FILL  | RAM line lands in buffer (zeroed if clean); write miss merges here
    // RESP  | ack cycle for read, write or error
    // CLEAR | ack cycle for clear-all-dirty
    typedef enum logic [2:0] {IDLE, FETCH, FILL, RESP, CLEAR} state_t;
    state_t state, state_next;

    logic                   req_write;
    logic [BW-1:0]          req_bank;
    logic [RW-1:0]          req_row;
    logic [CW-1:0]          req_col;
    logic [FIELD_WIDTH-1:0] req_data;

    logic                   buf_valid;
    logic [BW-1:0]          buf_bank;
    logic [RW-1:0]          buf_row;
    logic [LINE_WIDTH-1:0]  buf_data;

    logic                   dirty [NUM_BANKS][BANK_DEPTH];

    logic                   ram_we;
    logic                   ram_re;
    logic [BW-1:0]          ram_bank;
    logic [RW-1:0]          ram_row;
    logic [LINE_WIDTH-1:0]  ram_wdata;
    logic [LINE_WIDTH-1:0]  rd_bank [NUM_BANKS];

    logic                   hit;
    logic                   range_bad;
    logic [LINE_WIDTH-1:0]  fill_line;
    logic                   buf_load;
    logic [LINE_WIDTH-1:0]  buf_next;
    logic                   resp_load;
    logic                   resp_err;
    logic [FIELD_WIDTH-1:0] resp_data;
    logic                   req_load;
    logic                   clear_all;

    function automatic logic [FIELD_WIDTH-1:0] get_field(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [CW-1:0] col);
        get_field = '0;
        for (int f = 0; f < FIELDS; f++)
            if (int'(col) == f) get_field = line[f*FIELD_WIDTH +: FIELD_WIDTH];
    endfunction

    function automatic logic [LINE_WIDTH-1:0] put_field(input logic [LINE_WIDTH-1:0] line,
                                                        input logic [CW-1:0] col,
                                                        input logic [FIELD_WIDTH-1:0] data);
        put_field = line;
        for (int f = 0; f < FIELDS; f++)
            if (int'(col) == f) put_field[f*FIELD_WIDTH +: FIELD_WIDTH] = data;
    endfunction

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [LINE_WIDTH-1:0] ram [BANK_DEPTH];
        logic [LINE_WIDTH-1:0] rd_q;
        always_ff @(posedge clock) begin
            if (ram_we && ram_bank == BW'(b)) ram[ram_row] <= ram_wdata;
            if (ram_re && req_bank == BW'(b)) rd_q <= ram[req_row];
        end
        assign rd_bank[b] = rd_q;
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_bank   = req_bank;
        ram_row    = req_row;
        ram_wdata  = '0;
        buf_load   = 1'b0;
        buf_next   = buf_data;
        resp_load  = 1'b0;
        resp_err   = 1'b0;
        resp_data  = partial_vec_out;
        req_load   = 1'b0;
        clear_all  = 1'b0;
        hit        = buf_valid && buf_bank == bank_in && buf_row == row_addr_in;
        range_bad  = int'(col_addr_in) >= FIELDS || int'(bank_in) >= NUM_BANKS ||
                     int'(row_addr_in) >= BANK_DEPTH;
        // Clean rows read as zero no matter what the RAM still holds.
        fill_line  = dirty[req_bank][req_row] ? rd_bank[req_bank] : '0;

        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    clear_all  = 1'b1;
                    resp_load  = 1'b1;
                end else if (read_en || write_en) begin
                    if ((read_en && write_en) || range_bad) begin
                        state_next = RESP;
                        resp_load  = 1'b1;
                        resp_err   = 1'b1;
                    end else if (hit) begin
                        state_next = RESP;
                        resp_load  = 1'b1;
                        if (write_en) begin
                            buf_next  = put_field(buf_data, col_addr_in, partial_vec_in);
                            buf_load  = 1'b1;
                            ram_we    = 1'b1;
                            ram_bank  = bank_in;
                            ram_row   = row_addr_in;
                            ram_wdata = buf_next;
                            resp_data = partial_vec_in;
                        end else begin
                            resp_data = get_field(buf_data, col_addr_in);
                        end
                    end else begin
                        state_next = FETCH;
                        req_load   = 1'b1;
                    end
                end
            end
            FETCH: begin
                ram_re     = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                state_next = RESP;
                buf_load   = 1'b1;
                resp_load  = 1'b1;
                if (req_write) begin
                    buf_next  = put_field(fill_line, req_col, req_data);
                    ram_we    = 1'b1;
                    ram_wdata = buf_next;
                    resp_data = req_data;
                end else begin
                    buf_next  = fill_line;
                    resp_data = get_field(fill_line, req_col);
                end
            end
            RESP, CLEAR: state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            partial_vec_out <= '0;
            err             <= 1'b0;
            req_write       <= 1'b0;
            req_bank        <= '0;
            req_row         <= '0;
            req_col         <= '0;
            req_data        <= '0;
            buf_valid       <= 1'b0;
            buf_bank        <= '0;
            buf_row         <= '0;
            buf_data        <= '0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int r = 0; r < BANK_DEPTH; r++) dirty[b][r] <= 1'b0;
        end else begin
            if (resp_load) begin
                partial_vec_out <= resp_data;
                err             <= resp_err;
            end
            if (req_load) begin
                req_write <= write_en;
                req_bank  <= bank_in;
                req_row   <= row_addr_in;
                req_col   <= col_addr_in;
                req_data  <= partial_vec_in;
            end
            if (buf_load) buf_data <= buf_next;
            if (state == FILL) begin
                buf_valid <= 1'b1;
                buf_bank  <= req_bank;
                buf_row   <= req_row;
            end
            if (ram_we) dirty[ram_bank][ram_row] <= 1'b1;
            if (clear_all) begin
                buf_valid <= 1'b0;
                for (int b = 0; b < NUM_BANKS; b++)
                    for (int r = 0; r < BANK_DEPTH; r++) dirty[b][r] <= 1'b0;
            end
        end
    end

    assign ack  = (state == RESP) || (state == CLEAR);
    assign busy = (state != IDLE);

endmodule
